// File: rtl/vga_sync_to_count.sv
// vga_sync_to_count: regenerates col/row counters from incoming active-region
// H/V flags and tracks lock. Ports: i_Clk, i_Reset (async, high), i_HSync,
// i_VSync in; o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Frame_Start,
// o_Locked, o_Error out. All outputs are one clock behind the inputs.
module vga_sync_to_count #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic       o_Locked,
  output logic       o_Error
);

  localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);

  // Active sizes only describe the geometry; nothing is
  // built from them unless they are inconsistent.
  if (ACTIVE_COLS > TOTAL_COLS || ACTIVE_ROWS > TOTAL_ROWS)
  begin : g_bad_geom
  end

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t state, state_n;

  logic r_HSync;
  logic r_VSync;
  logic v_rise;
  logic h_rise;
  logic col_end;
  logic row_end;
  logic v_ok;
  logic h_ok;
  logic err_n;

  // A frame start also looks like a line start;
  // the frame check takes priority.
  assign v_rise = i_VSync & ~r_VSync;
  assign h_rise = i_HSync & ~r_HSync & ~v_rise;

  // Counter value while the edge is seen is the
  // last position of the previous line/frame.
  assign col_end = (o_Col_Count == LAST_COL);
  assign row_end = (o_Row_Count == LAST_ROW);
  assign v_ok    = col_end & row_end;
  assign h_ok    = col_end;

  assign o_Locked = (state == LOCKED);

  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (v_rise) state_n = ACQUIRE;
      end
      ACQUIRE: begin
        if (v_rise) begin
          if (v_ok) state_n = LOCKED;
          else      err_n   = 1'b1;
        end else if (h_rise && !h_ok) begin
          err_n   = 1'b1;
          state_n = SEARCH;
        end
      end
      LOCKED: begin
        if (v_rise && !v_ok) begin
          err_n   = 1'b1;
          state_n = ACQUIRE;
        end else if (h_rise && !h_ok) begin
          err_n   = 1'b1;
          state_n = SEARCH;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      // High so a flag already up at release
      // is not mistaken for an edge.
      r_HSync       <= 1'b1;
      r_VSync       <= 1'b1;
      o_HSync       <= 1'b0;
      o_VSync       <= 1'b0;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
      o_Frame_Start <= 1'b0;
      o_Error       <= 1'b0;
      state         <= SEARCH;
    end else begin
      r_HSync       <= i_HSync;
      r_VSync       <= i_VSync;
      o_HSync       <= i_HSync;
      o_VSync       <= i_VSync;
      o_Frame_Start <= v_rise;
      o_Error       <= err_n;
      state         <= state_n;
      if (v_rise) begin
        o_Col_Count <= '0;
        o_Row_Count <= '0;
      end else if (col_end) begin
        o_Col_Count <= '0;
        if (row_end) o_Row_Count <= '0;
        else         o_Row_Count <= o_Row_Count + 10'd1;
      end else begin
        o_Col_Count <= o_Col_Count + 10'd1;
      end
    end
  end

endmodule

// File: doc/vga_sync_to_count.md
# vga_sync_to_count

Receive-side companion to the VGA sync pulse generator: takes the active-region H/V sync flags (high while col < ACTIVE_COLS / row < ACTIVE_ROWS) and regenerates column/row counters aligned to them. It also tracks whether the incoming timing matches the configured frame geometry. It sits downstream of any sync source, for example after a pipeline stage or pattern generator, so that later stages can recover pixel coordinates without access to the source counters. Default geometry is 640x480 at a 25 MHz pixel clock.

## Interface
- TOTAL_COLS, 800, pixel clocks per line
- TOTAL_ROWS, 525, lines per frame
- ACTIVE_COLS, 640, active pixels per line; kept for geometry consistency, no logic depends on it
- ACTIVE_ROWS, 480, active lines per frame; kept for geometry consistency, no logic depends on it
- i_Clk  in  1  pixel clock; the only clock
- i_Reset  in  1  reset, asynchronous, active-high
- i_HSync  in  1  incoming H flag, high during active columns
- i_VSync  in  1  incoming V flag, high during active rows
- o_HSync  out  1  i_HSync delayed one clock
- o_VSync  out  1  i_VSync delayed one clock
- o_Col_Count  out  10  regenerated column, 0..TOTAL_COLS-1
- o_Row_Count  out  10  regenerated row, 0..TOTAL_ROWS-1
- o_Frame_Start  out  1  one-cycle pulse coincident with counts (0,0) after a realign
- o_Locked  out  1  high while the incoming timing matches the geometry
- o_Error  out  1  one-cycle pulse on a timing mismatch while acquiring or locked

## Operation
- Edge detect uses registered copies r_HSync and r_VSync.
  - VRise = i_VSync & ~r_VSync.
  - HRise = i_HSync & ~r_HSync & ~VRise.
- Counters free-run in the same way as the generator:
  - Col increments and wraps at TOTAL_COLS-1.
  - Row increments on the col wrap and wraps at TOTAL_ROWS-1.
- On VRise, the next edge forces col=0, row=0 and pulses o_Frame_Start. This realign happens in every state.
- HRise only checks timing; it never realigns.
- Expected position is the counter value in the cycle the edge is detected:
  - VRise expects col=TOTAL_COLS-1 and row=TOTAL_ROWS-1.
  - HRise expects col=TOTAL_COLS-1.
- FSM states are SEARCH, ACQUIRE and LOCKED. o_Locked = (state==LOCKED).
  - SEARCH: on VRise go to ACQUIRE. HRise is ignored. o_Error is never asserted.
  - ACQUIRE: VRise at the expected position goes to LOCKED. VRise at any other position pulses o_Error and stays in ACQUIRE, because the realign still occurs. HRise mismatch pulses o_Error and goes to SEARCH.
  - LOCKED: VRise mismatch pulses o_Error and goes to ACQUIRE. HRise mismatch pulses o_Error and goes to SEARCH.
- If no VRise arrives, the counters keep wrapping and the state does not change.
- If VRise and HRise fall in the same cycle (normal at frame start), only the VRise check applies.

## Timing
- Latency is 1 clock from i_HSync/i_VSync to o_HSync/o_VSync.
- Counts, o_Frame_Start, o_Locked and o_Error all change on the same edge as o_HSync/o_VSync, so all outputs are mutually aligned.
- For a generator-driven input, outputs at each edge equal the generator's count from one cycle earlier.
- Reset values:
  - o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Frame_Start, o_Locked and o_Error are all 0.
  - State is SEARCH.
  - r_HSync and r_VSync reset to 1, so a flag that is already high at reset release is not taken as an edge.
- Reset asserted mid-frame takes effect immediately (asynchronous). After release, the block re-acquires from SEARCH.
- o_Locked rises on the same edge as the o_Frame_Start of the second consecutive clean frame. It falls on the same edge as the o_Error pulse.
- Only the two counters are 10-bit. The TOTAL_*-1 comparisons are done at 10-bit width.

## Test plan
- Reset with both inputs held at 1, then release. Required: no o_Frame_Start until an input VSync rise occurs; all outputs stay 0 up to that point.
- Drive from a 800x525 generator. First VRise is detected at input cycle N.
  - At N+1: o_Frame_Start=1, counts (0,0), o_Locked=0.
  - At N+1+420000: second o_Frame_Start, and o_Locked goes to 1.
  - Continuous compare: outputs equal the generator's values delayed by one cycle.
- While locked, shorten one line to 799 clocks. Required: o_Error pulses exactly once at the early HRise and o_Locked drops. After the following two clean VRise events, o_Locked returns to 1.
- While locked, shorten one frame to 524 rows. Required: o_Error pulse at that VRise, counts realign to (0,0), o_Locked=0 (state ACQUIRE). The next clean frame sets o_Locked=1.
- Stop VSync (hold at 0) after lock. Required: row wraps 524->0 with no error, and o_Locked stays 1.
- Assert i_Reset for one cycle mid-line at col 300 while locked. Required: outputs clear immediately, o_Locked=0, and lock is re-acquired after two clean frame starts.
